// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I opcode encodings and scoreboard slot type
package riscv_pkg;

    // Register address width is fixed by the ISA (32 architectural registers)
    localparam int REG_AW = 5;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
    } sb_slot_t;

endpackage

// File: rtl/hazard_src_decode.sv
// rtl/hazard_src_decode.sv - which source registers an instruction reads, plus its rd field
module hazard_src_decode
    import riscv_pkg::*;
(
    input  logic [31:0]       inst,
    output logic              use_rs1,
    output logic              use_rs2,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd
);

    // funct3/funct7 do not affect which registers are read
    logic unused_fields;
    assign unused_fields = ^{inst[31:25], inst[14:12]};

    assign rd  = inst[11:7];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];

    // Source usage by opcode class; LUI/AUIPC/JAL and unknown opcodes read nothing
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (inst[6:0])
            OPC_R, OPC_S, OPC_B: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_I, OPC_LOAD, OPC_JALR: begin
                use_rs1 = 1'b1;
            end
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW stall / branch flush controller; HAZ_PERF_CNT_EN adds stall/flush counters
module hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [31:0]      id_inst_i,
    input  logic             id_reg_wen_i,
    input  logic             ex_br_taken_i,
    output logic             stall_o,
    output logic             bubble_o,
    output logic             flush_o,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
`endif
    output logic [31:0]      pending_o
);

    sb_slot_t          slots [PIPE_DEPTH];
    sb_slot_t          slot0_next;
    logic              use_rs1;
    logic              use_rs2;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              src1_live;
    logic              src2_live;
    logic              hazard;

    hazard_src_decode u_src_decode (
        .inst    (id_inst_i),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd)
    );

    // x0 reads are constant and can never depend on an in-flight write
    assign src1_live = use_rs1 && (rs1 != '0);
    assign src2_live = use_rs2 && (rs2 != '0);

    // RAW check against every slot; the register file has no write-through
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (slots[k].valid &&
                ((src1_live && (rs1 == slots[k].rd)) ||
                 (src2_live && (rs2 == slots[k].rd)))) begin
                hazard = 1'b1;
            end
        end
    end

    // A taken branch kills the stalled instruction, so flush overrides stall
    assign flush_o  = ex_br_taken_i;
    assign stall_o  = id_valid_i && hazard && !ex_br_taken_i;
    assign bubble_o = stall_o || ex_br_taken_i;

    // Only an instruction actually leaving ID with a real destination occupies slot 0
    always_comb begin
        slot0_next.valid = id_valid_i && !stall_o && !flush_o && id_reg_wen_i && (rd != '0);
        slot0_next.rd    = slot0_next.valid ? rd : '0;
    end

    // Slots advance every cycle; the downstream pipeline never stalls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else begin
            slots[0] <= slot0_next;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                slots[k] <= slots[k-1];
            end
        end
    end

    // Bitmap of registers with a write still in flight
    always_comb begin
        pending_o = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (slots[k].valid) begin
                pending_o[slots[k].rd] = 1'b1;
            end
        end
        pending_o[0] = 1'b0;
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating event counters for stall and flush cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (flush_o && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        id_reg_wen;
    logic        ex_br_taken;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [31:0] pending;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_inst_i     (id_inst),
        .id_reg_wen_i  (id_reg_wen),
        .ex_br_taken_i (ex_br_taken),
        .stall_o       (stall),
        .bubble_o      (bubble),
        .flush_o       (flush),
`ifdef HAZ_PERF_CNT_EN
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt),
`endif
        .pending_o     (pending)
    );

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one ID-stage cycle at the falling edge, then let outputs settle
    task automatic step(input logic v, input logic [31:0] inst, input logic wen, input logic br);
        @(negedge clk);
        id_valid    = v;
        id_inst     = inst;
        id_reg_wen  = wen;
        ex_br_taken = br;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic chk_out(input string tag, input logic s, input logic b, input logic f, input logic [31:0] p);
        chk({tag, ".stall"},   {31'b0, stall},  {31'b0, s});
        chk({tag, ".bubble"},  {31'b0, bubble}, {31'b0, b});
        chk({tag, ".flush"},   {31'b0, flush},  {31'b0, f});
        chk({tag, ".pending"}, pending,         p);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0;
        id_inst = 32'h0;
        id_reg_wen = 1'b0;
        ex_br_taken = 1'b0;

        // Reset state and flush passthrough
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_out("reset_br", 1'b0, 1'b1, 1'b1, 32'h0);
`ifdef HAZ_PERF_CNT_EN
        chk("reset.stall_cnt", stall_cnt, 32'd0);
        chk("reset.flush_cnt", flush_cnt, 32'd0);
`endif
        step(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(1);

        // Back-to-back RAW: three stall cycles
        step(1'b1, enc_r(5'd1, 5'd2, 5'd3), 1'b1, 1'b0);
        chk_out("s1.prod", 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, enc_r(5'd4, 5'd1, 5'd1), 1'b1, 1'b0);
            chk_out("s1.stall", 1'b1, 1'b1, 1'b0, 32'h2);
        end
        step(1'b1, enc_r(5'd4, 5'd1, 5'd1), 1'b1, 1'b0);
        chk_out("s1.go", 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3);
        chk_out("s1.drain", 1'b0, 1'b0, 1'b0, 32'h10);
        idle(1);

        // Load, NOP, store reading x5 through rs2: two stall cycles
        step(1'b1, enc_i(7'b0000011, 5'd5, 5'd6, 12'd0), 1'b1, 1'b0);
        chk_out("s2.lw", 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, enc_i(7'b0010011, 5'd0, 5'd0, 12'd0), 1'b1, 1'b0);
        chk_out("s2.nop", 1'b0, 1'b0, 1'b0, 32'h20);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, enc_s(5'd7, 5'd5, 12'd4), 1'b0, 1'b0);
            chk_out("s2.stall", 1'b1, 1'b1, 1'b0, 32'h20);
        end
        step(1'b1, enc_s(5'd7, 5'd5, 12'd4), 1'b0, 1'b0);
        chk_out("s2.go", 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3);

        // Writes and reads of x0 never interlock
        step(1'b1, enc_i(7'b0010011, 5'd0, 5'd0, 12'd1), 1'b1, 1'b0);
        step(1'b1, enc_r(5'd8, 5'd0, 5'd0), 1'b1, 1'b0);
        chk_out("s3.x0", 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1);
        chk_out("s3.x8", 1'b0, 1'b0, 1'b0, 32'h100);
        idle(3);

        // WAW with no RAW: overlapping x3 entries keep bit 3 set for 4 cycles
        step(1'b1, enc_r(5'd3, 5'd1, 5'd2), 1'b1, 1'b0);
        chk_out("s4.add", 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, enc_lui(5'd3, 20'h12345), 1'b1, 1'b0);
        chk_out("s4.lui", 1'b0, 1'b0, 1'b0, 32'h8);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk_out("s4.pend", 1'b0, 1'b0, 1'b0, 32'h8);
        end
        idle(1);
        chk_out("s4.clear", 1'b0, 1'b0, 1'b0, 32'h0);

        // Flush on the second stall cycle overrides the stall
        step(1'b1, enc_r(5'd1, 5'd2, 5'd3), 1'b1, 1'b0);
        step(1'b1, enc_r(5'd4, 5'd1, 5'd1), 1'b1, 1'b0);
        chk_out("s5.stall", 1'b1, 1'b1, 1'b0, 32'h2);
        step(1'b1, enc_r(5'd4, 5'd1, 5'd1), 1'b1, 1'b1);
        chk_out("s5.flush", 1'b0, 1'b1, 1'b1, 32'h2);
        step(1'b1, enc_r(5'd6, 5'd1, 5'd0), 1'b1, 1'b0);
        chk_out("s5.after", 1'b1, 1'b1, 1'b0, 32'h2);
        step(1'b1, enc_r(5'd6, 5'd1, 5'd0), 1'b1, 1'b0);
        chk_out("s5.go", 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3);

        // Reset mid-stall drops every slot
        step(1'b1, enc_r(5'd9, 5'd1, 5'd2), 1'b1, 1'b0);
        step(1'b1, enc_r(5'd10, 5'd9, 5'd0), 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk_out("s6.stall", 1'b1, 1'b1, 1'b0, 32'h200);
        step(1'b1, enc_r(5'd10, 5'd9, 5'd0), 1'b1, 1'b0);
        chk_out("s6.reset", 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        idle(1);

`ifdef HAZ_PERF_CNT_EN
        // Counters: three stall cycles and one flush
        chk("s7.stall_cnt0", stall_cnt, 32'd0);
        step(1'b1, enc_r(5'd1, 5'd2, 5'd3), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, enc_r(5'd4, 5'd1, 5'd1), 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        idle(1);
        chk("s7.stall_cnt", stall_cnt, 32'd3);
        chk("s7.flush_cnt", flush_cnt, 32'd1);
        rst = 1'b1;
        idle(1);
        chk("s7.stall_clr", stall_cnt, 32'd0);
        chk("s7.flush_clr", flush_cnt, 32'd0);
        rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Stall and flush controller for the stalling (non-forwarding) RV32I pipeline. It sits beside the ID stage, fed by the fetched instruction and the RegWen decoded for it.
- Keeps a shift-register scoreboard of in-flight destination registers (EX, MEM, WB). Stalls ID on a RAW hazard and inserts a bubble into ID/EX.
- Flushes IF/ID and ID/EX when EX resolves a taken branch or jump.

Parameters:
- PIPE_DEPTH, 3, number of scoreboard slots (EX, MEM, WB). The register file is not write-through, so all slots are checked.
- REG_AW, 5, register address width.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- id_valid_i  in  1  ID holds a real instruction (0 for a bubble)
- id_inst_i  in  32  instruction in ID
- id_reg_wen_i  in  1  RegWen decoded for id_inst_i
- ex_br_taken_i  in  1  br_sel of the instruction currently in EX (branch taken, JAL or JALR)
- stall_o  out  1  hold PC and IF/ID
- bubble_o  out  1  zero all ID/EX control fields this cycle
- flush_o  out  1  kill IF/ID and ID/EX contents
- pending_o  out  32  bitmap of registers with a write in flight; bit 0 is always 0

Behaviour:
- Slot k is {valid, rd[REG_AW-1:0]}. Slot 0 is EX; slot PIPE_DEPTH-1 is WB.
- Reset: all slots invalid, counters 0. Outputs are combinational on state and inputs, so after reset stall_o=0, bubble_o=0, pending_o=0, and flush_o follows ex_br_taken_i.
- Source usage by opcode:
  - R (0110011), S (0100011), B (1100011): rs1 and rs2.
  - I-ALU (0010011), LOAD (0000011), JALR (1100111): rs1 only.
  - LUI, AUIPC, JAL and unknown opcodes: no sources.
  - A source equal to x0 never causes a hazard.
- hazard = id_valid_i AND some used rsN equals the rd of some valid slot.
- flush_o = ex_br_taken_i.
- stall_o = hazard AND NOT ex_br_taken_i. A flush overrides a stall, because the stalled instruction is being killed.
- bubble_o = stall_o OR ex_br_taken_i.
- Every cycle the slots shift: slot[k] <= slot[k-1] for k >= 1. The downstream pipeline never stalls.
- Slot 0 update:
  - Loads {1, rd} only if id_valid_i=1, stall_o=0, flush_o=0, id_reg_wen_i=1 and rd != 0.
  - Otherwise slot 0 loads invalid.
- The branch or jump in EX is already in slot 0 when it asserts ex_br_taken_i, so its own rd (JAL/JALR link) is preserved and shifts onward.
- Stall latency: a consumer immediately following its producer stalls exactly PIPE_DEPTH cycles. With one independent instruction between them, it stalls PIPE_DEPTH-1 cycles.
- pending_o = OR over valid slots of (1 << rd).
- Simultaneous flush and hazard: flush wins, stall_o=0, slot 0 loads invalid.
- Reset asserted mid-stall: the next cycle has all slots invalid and stall_o=0.
- WAW with no RAW (e.g. LUI x5 after ADD x5) causes no stall. Both entries may coexist in the scoreboard.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds output ports stall_cnt_o[CNT_W] and flush_cnt_o[CNT_W].
  - Each increments by 1 per cycle in which stall_o / flush_o is high.
  - Each saturates at all-ones and is cleared by rst_i.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package riscv_pkg:
  - Opcode constants OPC_R, OPC_I, OPC_S, OPC_B, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD. These are the same encodings ConTrolUnit decodes.
  - typedef sb_slot_t {logic valid; logic [REG_AW-1:0] rd;}.
- One sub-module, hazard_src_decode: combinational, inst in, use_rs1/use_rs2/rs1/rs2/rd out.

Test Plan:
- ADD x1,x2,x3 then ADD x4,x1,x1 back-to-back -> stall_o=bubble_o=1 for exactly 3 cycles, then 0. pending_o=0x2 during the stall.
- LW x5,0(x6), NOP (ADDI x0,x0,0), SW x5,4(x7) -> stall for 2 cycles (hazard through rs2 of the store). The NOP writes x0 and creates no slot.
- ADDI x0,x0,1 then ADD x8,x0,x0 -> no stall, pending_o=0.
- ADD x3,... then LUI x3,0x12345 -> no stall. pending_o=0x8 for 4 consecutive cycles (two overlapping entries).
- Stall on x1 while ex_br_taken_i=1 on the 2nd stall cycle -> that cycle has stall_o=0, flush_o=1, bubble_o=1. The following cycle has slot 0 invalid and the JAL rd (x1) present in slot 1.
- With HAZ_PERF_CNT_EN, scenario 1 plus one flush -> stall_cnt_o=3, flush_cnt_o=1. Asserting rst_i clears both to 0 the next cycle.
